// File: rtl/simple_processor_pkg.sv
// Shared types and constants for the simple processor memory subsystem.
package simple_processor_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int NUM_DMEM_REQ         = 2;
  localparam int DMEM_TIMEOUT_DEFAULT = 16;

  // DMEM arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker. A lone requester wins outright;
// on a tie the port that was not served last wins. Shared with the IMEM side.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic [1:0] gnt
);

  // One-hot winner selection.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = last_gnt ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single DMEM port between the core load/store path (port 0) and
// the debug/loader path (port 1), one outstanding transaction at a time.
//
// Requester handshake: a port raises req_i with addr/we/wdata stable and holds
// it until it sees gnt_o for that port (a one-cycle pulse in the same cycle the
// fields are latched). Completion is a one-cycle rvalid_o pulse carrying
// rdata_o/err_o; both read 0 outside that pulse. A port still holding req_i
// after its gnt is starting a new transaction.
// DMEM handshake: dmem_req_o stays high with stable address/data until
// dmem_ack_i; ack outside an access is ignored.
//
// Optional build macro DMEM_TIMEOUT_EN: abort an access after TIMEOUT_CYCLES
// cycles without ack and report it with err_o.
module dmem_arbiter
  import simple_processor_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_DMEM_REQ
`ifdef DMEM_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
`endif
) (
  input  logic                                clk_i,
  input  logic                                arst_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  addr_i,
  input  logic [NUM_REQ-1:0]                  we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic [NUM_REQ-1:0]                  rvalid_o,
  output logic [DATA_WIDTH-1:0]               rdata_o,
  output logic                                err_o,
  output logic                                dmem_req_o,
  output logic [DATA_WIDTH-1:0]               dmem_addr_o,
  output logic                                dmem_we_o,
  output logic [DATA_WIDTH-1:0]               dmem_wdata_o,
  input  logic [DATA_WIDTH-1:0]               dmem_rdata_i,
  input  logic                                dmem_ack_i,
  output arb_state_t                          state_o
);

  arb_state_t            state_q, state_d;
  logic [NUM_REQ-1:0]    win;
  logic                  owner_q;
  logic                  last_gnt_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic                  we_q;
  logic                  err_q;
  logic                  timeout;

  rr_arb2 u_rr_arb2 (
    .req      (req_i),
    .last_gnt (last_gnt_q),
    .gnt      (win)
  );

`ifdef DMEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q;

  // Counts unacknowledged ACCESS cycles; held at zero outside ACCESS so every
  // access starts from a clean count.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= '0;
    end else if (state_q != ACCESS) begin
      cnt_q <= '0;
    end else if (!dmem_ack_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expiry only when no ack arrives in the same cycle; a late ack still wins.
  assign timeout = (state_q == ACCESS) && !dmem_ack_i &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|req_i) state_d = ACCESS;
      ACCESS:  if (dmem_ack_i || timeout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latches, response capture and round-robin history.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      owner_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      last_gnt_q <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|req_i) begin
            owner_q <= win[1];
            addr_q  <= addr_i[win[1]];
            we_q    <= we_i[win[1]];
            wdata_q <= wdata_i[win[1]];
          end
        end
        ACCESS: begin
          if (dmem_ack_i) begin
            rdata_q <= we_q ? '0 : dmem_rdata_i;
            err_q   <= 1'b0;
          end else if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
          end
        end
        RESP:    last_gnt_q <= owner_q;
        default: ;
      endcase
    end
  end

  // Requester-facing outputs; grant is suppressed while reset is asserted.
  always_comb begin
    gnt_o    = '0;
    rvalid_o = '0;
    rdata_o  = '0;
    err_o    = 1'b0;
    if (state_q == IDLE && !arst_i) begin
      gnt_o = win;
    end
    if (state_q == RESP) begin
      rvalid_o[owner_q] = 1'b1;
      rdata_o           = rdata_q;
      err_o             = err_q;
    end
  end

  assign dmem_req_o   = (state_q == ACCESS);
  assign dmem_addr_o  = addr_q;
  assign dmem_we_o    = we_q & dmem_req_o;
  assign dmem_wdata_o = wdata_q;
  assign state_o      = state_q;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Sequences and shares the single data-memory (DMEM) port between two requesters.
  - Port 0: core load/store path.
  - Port 1: debug/loader path.
- Runs the DMEM req/ack handshake for one outstanding transaction at a time.
- Round-robin fairness between the two ports.
- Returns read data or write completion to the owning requester.
- Sits between the execute-stage memory unit and the DMEM macro.

Parameters:
- NUM_REQ, 2, number of requester ports; fixed at 2 in this revision.
- TIMEOUT_CYCLES, 16, cycles in ACCESS without ack before abort; used only with DMEM_TIMEOUT_EN.

Ports:
- clk_i  in  1  system clock.
- arst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_REQ  per-port transaction request; held until gnt.
- addr_i  in  NUM_REQ x DATA_WIDTH  per-port byte address.
- we_i  in  NUM_REQ  per-port write enable (1 = store, 0 = load).
- wdata_i  in  NUM_REQ x DATA_WIDTH  per-port store data.
- gnt_o  out  NUM_REQ  one-hot, 1-cycle pulse: request accepted and latched.
- rvalid_o  out  NUM_REQ  one-hot, 1-cycle pulse: transaction complete.
- rdata_o  out  DATA_WIDTH  load data, valid with rvalid_o.
- err_o  out  1  transaction aborted, valid with rvalid_o.
- dmem_req_o  out  1  DMEM access active.
- dmem_addr_o  out  DATA_WIDTH  latched address.
- dmem_we_o  out  1  latched write enable, gated by dmem_req_o.
- dmem_wdata_o  out  DATA_WIDTH  latched store data.
- dmem_rdata_i  in  DATA_WIDTH  DMEM read data, valid with ack.
- dmem_ack_i  in  1  DMEM completion.

Behaviour:
- Reset (async, arst_i=1):
  - FSM goes to IDLE.
  - All outputs are 0.
  - Latched addr/wdata/we/owner are cleared.
  - last_gnt = 1, so port 0 wins the first tie.
- FSM states: IDLE, ACCESS, RESP (enum arb_state_t).
- IDLE:
  - If any req_i is set, select the winner.
    - Single requester wins outright.
    - When both request, the port other than last_gnt wins.
  - Latch addr, we, wdata and owner; pulse gnt_o[owner]; next state ACCESS.
  - If no request, stay in IDLE.
- ACCESS:
  - dmem_req_o=1; dmem_addr_o, dmem_we_o and dmem_wdata_o driven from the latches, stable for the whole state.
  - On dmem_ack_i=1: if the transaction is a load, capture dmem_rdata_i into the rdata register. Next state RESP.
  - Ack is accepted in the first ACCESS cycle (zero-wait DMEM).
- RESP:
  - rvalid_o[owner]=1 for one cycle.
  - rdata_o holds the captured data for a load; 0 for a store.
  - last_gnt updated to owner; next state IDLE.
- Latency:
  - gnt at cycle N; dmem_req_o from N+1.
  - With ack at N+1, rvalid at N+2.
  - Back-to-back throughput: one transaction per 3 cycles.
- req_i seen in ACCESS or RESP is ignored (not queued); the requester keeps holding req_i until gnt.
- A requester still asserting req_i in the cycle after its gnt is treated as a new transaction.
- dmem_ack_i outside ACCESS is ignored.
- Async reset mid-transaction: the transaction is dropped and no rvalid is produced. DMEM must tolerate abandonment.
- rdata_o and err_o read 0 whenever rvalid_o == 0.

Optional Feature:
- Macro: DMEM_TIMEOUT_EN.
- Defined:
  - Cycle counter, cleared on entry to ACCESS, increments each cycle in ACCESS without ack.
  - When the count reaches TIMEOUT_CYCLES-1 without ack: dmem_req_o drops the next cycle and the FSM goes to RESP with err_o=1 and rdata_o=0.
  - Ack arriving in the same cycle as expiry wins: normal completion, err_o=0.
- Not defined: no counter; ACCESS waits indefinitely; err_o tied to 0.

Decomposition:
- simple_processor_pkg:
  - DATA_WIDTH (existing).
  - arb_state_t enum {IDLE, ACCESS, RESP}.
  - NUM_DMEM_REQ = 2.
  - DMEM_TIMEOUT_DEFAULT = 16.
- Sub-module rr_arb2: combinational 2-way round-robin picker (req, last_gnt -> one-hot winner). Kept separate for reuse by the IMEM side.

Test Plan:
- Reset release, req_i=01, addr=0x10, we=0; ack next cycle with rdata=0xDEADBEEF -> gnt_o=01 at N, dmem_req_o=1 / addr 0x10 at N+1, rvalid_o=01 and rdata_o=0xDEADBEEF at N+2.
- Both ports request continuously; port0 stores 0xAAAA to 0x4, port1 loads 0x8 -> grants alternate 01,10,01,10; dmem_we_o=1 only during port0 ACCESS; dmem_wdata_o=0xAAAA.
- Ack delayed 5 cycles -> dmem_req_o/addr/we/wdata held constant for 5 cycles; port1 req during ACCESS not granted until the cycle after RESP.
- arst_i pulsed during ACCESS -> all outputs 0 immediately; no rvalid; next request after release is granted to port 0.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=16, no ack -> dmem_req_o high 16 cycles, then rvalid with err_o=1, rdata_o=0.
- DMEM_TIMEOUT_EN, ack in the expiry cycle -> normal completion with err_o=0.
